// File: rtl/sample_frame_buffer_pkg.sv
// Shared sizing for the sample capture path.
// Widths and defaults common to down_sampler and the frame buffer.
package sample_frame_buffer_pkg;

  localparam int SAMPLE_WIDTH = 32;
  localparam int FRAME_LEN_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 16;

  // Counter width that stays legal when the range is a single value.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_frame_buffer_fifo.sv
// First-word-fall-through synchronous FIFO.
// Accepts a write when full only if a read retires in the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_req,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     push,
  output logic                     pop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = rd_req & ~empty;
  assign push    = wr_req & (~full | pop);
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates use.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_frame_buffer.sv
// Captures decimated samples and streams them out in frames.
// Flags sticky overflow when back-pressure forces a drop.
module sample_frame_buffer
  import sample_frame_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        data_in_vld,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  localparam int FW = ctr_width(FRAME_LEN);
  localparam logic [FW-1:0] LAST_IDX = FW'(FRAME_LEN - 1);

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic [FW-1:0] cnt;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (data_in_vld),
    .wr_data (data_in),
    .rd_req  (m_ready),
    .rd_data (m_data),
    .count   (fill_level),
    .full    (full),
    .empty   (empty),
    .push    (push),
    .pop     (pop)
  );

  assign m_valid = ~empty;
  assign drop    = data_in_vld & ~push;
  assign m_last  = m_valid & (cnt == LAST_IDX);

  // Frame position advances on delivered words only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= (cnt == LAST_IDX) ? '0 : cnt + FW'(1);
    end
  end

  // Sticky overflow; a drop beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Scoreboard bench for sample_frame_buffer.
// Directed vectors plus a seeded back-pressure run.
module tb_sample_frame_buffer;

  localparam int W = 32;
  localparam int D = 16;
  localparam int F = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         data_in_vld;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic [4:0]   fill_level;
  logic         overflow;
  logic         clr_overflow;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q [$];
  int           lvl;
  bit           ov_m;
  int           idx;
  int           lasts;
  bit           stall;
  logic [W-1:0] held;
  logic [W-1:0] e;
  int unsigned  r;

  sample_frame_buffer #(
    .DATA_WIDTH (W),
    .FIFO_DEPTH (D),
    .FRAME_LEN  (F)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_vld  (data_in_vld),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted output word.
  always @(negedge clk) begin
    if (rst) begin
      idx = 0;
      stall = 0;
    end else begin
      if (stall && m_valid) chk("stable", m_data, held);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underrun: got %0h expected none", m_data);
        end else begin
          e = exp_q.pop_front();
          chk("data", m_data, e);
        end
        chk("last", m_last, (idx % F) == F - 1);
        if (m_last) lasts++;
        idx++;
      end
      stall = m_valid && !m_ready;
      held = m_data;
    end
  end

  task automatic cyc(input bit vld, input logic [W-1:0] d,
                     input bit rdy, input bit clr);
    bit pop_m;
    bit push_m;
    data_in = d;
    data_in_vld = vld;
    m_ready = rdy;
    clr_overflow = clr;
    pop_m = (lvl > 0) && rdy;
    push_m = vld && ((lvl < D) || pop_m);
    if (push_m) exp_q.push_back(d);
    lvl = lvl + int'(push_m) - int'(pop_m);
    if (vld && !push_m) ov_m = 1;
    else if (clr) ov_m = 0;
    @(posedge clk);
    #1;
    data_in_vld = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_fill"}, fill_level, lvl);
    chk({tag, "_valid"}, m_valid, lvl > 0);
    chk({tag, "_ovf"}, overflow, ov_m);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    exp_q.delete();
    lvl = 0;
    ov_m = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    data_in = '0;
    data_in_vld = 1'b0;
    m_ready = 1'b0;
    clr_overflow = 1'b0;
    lvl = 0;
    ov_m = 0;
    lasts = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_fill", fill_level, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // Reset mid-stream with five words queued
    for (int i = 0; i < 5; i++) cyc(1, 32'hA0 + i, 0, 0);
    check_state("pre_rst");
    rst = 1'b1;
    #1;
    chk("mid_rst_fill", fill_level, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    exp_q.delete();
    lvl = 0;
    ov_m = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1, 32'hB0 + i, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    check_state("post_rst");

    // One-cycle latency
    do_reset();
    cyc(1, 32'h0000_1234, 1, 0);
    chk("lat_valid", m_valid, 1);
    chk("lat_data", m_data, 32'h1234);
    chk("lat_fill", fill_level, 1);
    cyc(0, 0, 1, 0);
    chk("lat_fill_after", fill_level, 0);
    chk("lat_valid_after", m_valid, 0);

    // Framing over two frames
    do_reset();
    lasts = 0;
    for (int i = 0; i < 16; i++) cyc(1, W'(i), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("frame_lasts", lasts, 2);

    // Overflow with stalled consumer
    do_reset();
    for (int i = 0; i < 18; i++) cyc(1, W'(i), 0, 0);
    chk("ovf_fill", fill_level, 16);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0);
    check_state("ovf_drain");
    cyc(0, 0, 1, 1);
    chk("ovf_clear", overflow, 0);

    // Push while full with a simultaneous pop
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 32'h100 + i, 0, 0);
    cyc(1, 32'h200, 1, 0);
    chk("fullpop_fill", fill_level, 16);
    chk("fullpop_ovf", overflow, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0);
    check_state("fullpop_drain");

    // Random back-pressure
    do_reset();
    r = $urandom(32'd2024);
    begin
      int n = 0;
      int guard = 0;
      while (n < 1000 && guard < 20000) begin
        bit v;
        bit rd;
        v = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 1) != 0);
        cyc(v, $urandom, rd, 0);
        n += int'(v);
        guard++;
      end
      chk("rand_strobes", n, 1000);
    end
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, 0);
    check_state("rand_end");
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
